// File: rtl/gnss_code_mem_db.sv
// Double-buffered spreading-code memory for time-multiplexed GNSS channels.
// The host fills the shadow bank while a round-robin producer prefetches each channel's next chip from the active bank.
module gnss_code_mem_db #(
  parameter int unsigned CHANS    = 12,
  parameter int unsigned CODEBITS = 12,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CODEBITS-1:0]          code_len,
  input  logic                         wr,
  input  logic [CHANS-1:0]             wr_data,
  input  logic                         wr_clr,
  input  logic                         swap,
  input  logic [CHANS*CODEBITS-1:0]    nchip_n,
  input  logic [CHANS-1:0]             full_chip,
  output logic [CHANS-1:0]             code_o,
  output logic                         active,
  output logic                         load_done,
  output logic [1:0]                   err
);

  localparam int unsigned CPW   = (CHANS > 1) ? $clog2(CHANS) : 1;
  localparam int unsigned AW    = CODEBITS + 1;
  localparam int unsigned DEPTH = 2 ** AW;

  logic [CHANS-1:0]    mem [DEPTH];
  logic [CHANS-1:0]    dout;
  logic [CHANS-1:0]    code_n;
  logic [CHANS-1:0]    code_q;
  logic [CODEBITS-1:0] waddr;
  logic [CODEBITS-1:0] raddr;
  logic [CODEBITS-1:0] raddr_nxt;
  logic [CODEBITS-1:0] nchip_sel;
  logic [CPW-1:0]      ch_p;
  logic [CPW-1:0]      ch_iss;
  logic                rbank;
  logic                swap_pend;
  logic                swap_now;
  logic                wr_ok;

  // Issue for the channel that will own the slot once the read pipeline has drained.
  always_comb begin
    ch_iss    = CPW'((32'(ch_p) + RD_LAT) % CHANS);
    nchip_sel = nchip_n[ch_iss*CODEBITS +: CODEBITS];
    raddr_nxt = (nchip_sel >= code_len - CODEBITS'(1)) ? '0 : nchip_sel + CODEBITS'(1);
  end

  assign swap_now = swap_pend && (ch_p == CPW'(CHANS - 1));
  assign wr_ok    = wr && !wr_clr && !swap_now && (waddr < code_len);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[{~active, waddr}] <= wr_data;
  end

  // Registered read port; rbank travels with raddr so in-flight reads finish on their own bank.
  always_ff @(posedge clk) begin
    dout <= mem[{rbank, raddr}];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_p      <= '0;
      raddr     <= '0;
      rbank     <= 1'b0;
      code_n    <= '0;
      code_q    <= '0;
      waddr     <= '0;
      active    <= 1'b0;
      swap_pend <= 1'b0;
      load_done <= 1'b0;
      err       <= '0;
    end else begin
      ch_p         <= (ch_p == CPW'(CHANS - 1)) ? '0 : ch_p + CPW'(1);
      raddr        <= raddr_nxt;
      rbank        <= active;
      code_n[ch_p] <= dout[ch_p];
      code_q       <= (full_chip & code_n) | (~full_chip & code_q);

      // Bank exchange lands at the end of a round so the shadow restarts cleanly.
      if (swap_now) begin
        active    <= ~active;
        swap_pend <= 1'b0;
        load_done <= 1'b0;
        waddr     <= '0;
      end else begin
        if (swap) begin
          if (load_done) swap_pend <= 1'b1;
          else           err[1]    <= 1'b1;
        end
        if (wr_clr) begin
          waddr     <= '0;
          load_done <= 1'b0;
        end else if (wr) begin
          if (waddr < code_len) begin
            waddr <= waddr + CODEBITS'(1);
            if (waddr + CODEBITS'(1) == code_len) load_done <= 1'b1;
          end else begin
            err[0] <= 1'b1;
          end
        end
      end
    end
  end

  // New chip shows combinationally during its full_chip cycle, then is held.
  assign code_o = (full_chip & code_n) | (~full_chip & code_q);

endmodule

// File: tb/tb_gnss_code_mem_db.sv
// Bench for gnss_code_mem_db: directed load/swap/error steps plus randomized chip lookups
// checked against an array model of both banks and the per-channel held outputs.
module tb_gnss_code_mem_db;

  localparam int unsigned CHANS = 12;
  localparam int unsigned CB    = 12;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [CB-1:0]         code_len;
  logic                  wr;
  logic [CHANS-1:0]      wr_data;
  logic                  wr_clr;
  logic                  swap;
  logic [CHANS*CB-1:0]   nchip_n;
  logic [CHANS-1:0]      full_chip;
  logic [CHANS-1:0]      code_o;
  logic                  active;
  logic                  load_done;
  logic [1:0]            err;

  int                    nch [CHANS];
  logic [CHANS-1:0]      mm [2][4096];
  logic [CHANS-1:0]      mq;
  bit                    mact;
  int                    mlen;
  int                    errors = 0;
  int                    checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < CHANS; g++) begin : g_nchip
    assign nchip_n[g*CB +: CB] = CB'(nch[g]);
  end

  gnss_code_mem_db #(.CHANS(CHANS), .CODEBITS(CB), .RD_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .code_len  (code_len),
    .wr        (wr),
    .wr_data   (wr_data),
    .wr_clr    (wr_clr),
    .swap      (swap),
    .nchip_n   (nchip_n),
    .full_chip (full_chip),
    .code_o    (code_o),
    .active    (active),
    .load_done (load_done),
    .err       (err)
  );

  // Chip that follows n in a code of mlen chips; anything past the end restarts the code.
  function automatic int nxt(int n);
    return (n >= mlen - 1) ? 0 : n + 1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int n, int start, bit par);
    logic [CHANS-1:0] d;
    bit bank;
    bank = ~mact;
    for (int a = start; a < start + n; a++) begin
      for (int c = 0; c < CHANS; c++) d[c] = par ? ^(a ^ c) : 1'($urandom);
      wr_data     = d;
      wr          = 1'b1;
      mm[bank][a] = d;
      step();
    end
    wr = 1'b0;
  endtask

  task automatic pulse_swap();
    swap = 1'b1;
    step();
    swap = 1'b0;
  endtask

  task automatic pick();
    int r;
    for (int c = 0; c < CHANS; c++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      nch[c] = mlen - 1;
      else if (r == 1) nch[c] = mlen - 2;
      else if (r == 2) nch[c] = mlen;
      else             nch[c] = int'($urandom_range(0, mlen - 1));
    end
  endtask

  task automatic rand_check(string tag, int iters);
    logic [CHANS-1:0] fc;
    logic [CHANS-1:0] exp;
    for (int it = 0; it < iters; it++) begin
      pick();
      repeat (CHANS + 2) step();
      fc = CHANS'($urandom_range(1, (1 << CHANS) - 1));
      full_chip = fc;
      #1;
      for (int c = 0; c < CHANS; c++) exp[c] = fc[c] ? mm[mact][nxt(nch[c])][c] : mq[c];
      chk(tag, 32'(code_o), 32'(exp));
      step();
      full_chip = '0;
      mq = exp;
      #1;
      chk({tag, "_hold"}, 32'(code_o), 32'(mq));
    end
  endtask

  task automatic pulse1(string tag, int ch, int n, int addr);
    logic [CHANS-1:0] m;
    nch[ch] = n;
    repeat (CHANS + 2) step();
    m = '0;
    m[ch] = 1'b1;
    full_chip = m;
    #1;
    chk(tag, 32'(code_o[ch]), 32'(mm[mact][addr][ch]));
    step();
    full_chip = '0;
    mq[ch] = mm[mact][addr][ch];
  endtask

  // Staggered per-channel refreshes every 16 cycles with a swap in the middle.
  task automatic swap_traffic();
    logic [CHANS-1:0] fc;
    logic [CHANS-1:0] exp;
    int s;
    int win;
    bit b;
    s   = 5 * 16 + 7;
    win = s + 2 * CHANS + 4;
    pick();
    repeat (16) step();
    for (int cyc = 0; cyc < 12 * 16; cyc++) begin
      fc = '0;
      for (int c = 0; c < CHANS; c++)
        if ((cyc % 16) == c && !(cyc > s && cyc < win)) fc[c] = 1'b1;
      b = (cyc <= s) ? mact : ~mact;
      swap = (cyc == s);
      full_chip = fc;
      #1;
      for (int c = 0; c < CHANS; c++) exp[c] = fc[c] ? mm[b][nxt(nch[c])][c] : mq[c];
      chk("t6_code", 32'(code_o), 32'(exp));
      step();
      swap = 1'b0;
      full_chip = '0;
      mq = exp;
      for (int c = 0; c < CHANS; c++)
        if ((cyc % 16) == c) nch[c] = nxt(nch[c]);
    end
    mact = ~mact;
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; wr_clr = 1'b0; swap = 1'b0;
    wr_data = '0; full_chip = '0; code_len = CB'(4092);
    mlen = 4092; mact = 1'b0; mq = '0;
    for (int c = 0; c < CHANS; c++) nch[c] = 0;

    repeat (3) step();
    chk("rst_code",   32'(code_o), 32'(0));
    chk("rst_active", 32'(active), 32'(0));
    chk("rst_err",    32'(err), 32'(0));
    chk("rst_ldone",  32'(load_done), 32'(0));
    rst = 1'b0;
    step();

    // full-length code load and swap
    load(4091, 0, 1'b1);
    chk("t2_ldone_early", 32'(load_done), 32'(0));
    load(1, 4091, 1'b1);
    chk("t2_ldone", 32'(load_done), 32'(1));
    pulse_swap();
    repeat (CHANS) step();
    mact = 1'b1;
    chk("t2_active", 32'(active), 32'(mact));
    chk("t2_ldone_clr", 32'(load_done), 32'(0));
    rand_check("t2", 150);

    // wrap at the end of the code
    pulse1("t3_last", 3, 4090, 4091);
    pulse1("t3_wrap", 3, 4091, 0);
    pulse1("t3_beyond", 3, 4095, 0);
    pulse1("t3_first", 7, 0, 1);

    // runtime code length and write overflow
    code_len = CB'(2046);
    mlen = 2046;
    wr_clr = 1'b1;
    step();
    wr_clr = 1'b0;
    chk("t4_ldone_clr", 32'(load_done), 32'(0));
    load(2046, 0, 1'b0);
    chk("t4_ldone", 32'(load_done), 32'(1));
    chk("t4_err_none", 32'(err), 32'(0));
    wr_data = CHANS'($urandom);
    wr = 1'b1;
    step();
    wr = 1'b0;
    chk("t4_ovf", 32'(err), 32'(1));
    chk("t4_ldone_kept", 32'(load_done), 32'(1));
    pulse_swap();
    repeat (CHANS) step();
    mact = 1'b0;
    chk("t4_active", 32'(active), 32'(mact));
    rand_check("t4", 60);

    // swap refused on a partial load
    wr_clr = 1'b1;
    step();
    wr_clr = 1'b0;
    load(100, 0, 1'b0);
    pulse_swap();
    chk("t5_err", 32'(err), 32'(3));
    repeat (CHANS) step();
    chk("t5_active", 32'(active), 32'(mact));
    rand_check("t5", 40);

    // complete the load, then swap under traffic
    load(1946, 100, 1'b0);
    chk("t6_ldone", 32'(load_done), 32'(1));
    swap_traffic();
    chk("t6_active", 32'(active), 32'(mact));
    rand_check("t6_after", 20);

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("t1_code",   32'(code_o), 32'(0));
    chk("t1_active", 32'(active), 32'(0));
    chk("t1_err",    32'(err), 32'(0));
    chk("t1_ldone",  32'(load_done), 32'(0));
    mact = 1'b0;
    mq = '0;
    repeat (2) step();
    rst = 1'b0;
    repeat (CHANS + 4) step();
    chk("t1_hold", 32'(code_o), 32'(0));
    pulse1("t1_first", 5, 10, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
